// File: rtl/vga_timing_ctrl_pkg.sv
// Shared VGA timing constants and types for the timing controller and every renderer
// that needs to place content relative to the visible area.
package vga_timing_ctrl_pkg;

  localparam int CLK_DIV = 4;
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_TOTAL = 800;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_TOTAL = 525;

  typedef logic [9:0]  coord_t;
  typedef logic [11:0] color_t;
  typedef logic [3:0]  chan_t;

  typedef struct packed {
    logic [7:0] clk_div;
    coord_t     h_vis;
    coord_t     h_fp;
    coord_t     h_sync;
    coord_t     h_total;
    coord_t     v_vis;
    coord_t     v_fp;
    coord_t     v_sync;
    coord_t     v_total;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    clk_div: 8'(CLK_DIV),
    h_vis:   10'(H_VIS),
    h_fp:    10'(H_FP),
    h_sync:  10'(H_SYNC),
    h_total: 10'(H_TOTAL),
    v_vis:   10'(V_VIS),
    v_fp:    10'(V_FP),
    v_sync:  10'(V_SYNC),
    v_total: 10'(V_TOTAL)
  };

  // True when v lies in [lo, lo+len); widened by one bit so the upper bound cannot wrap.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t len);
    return (v >= lo) && ({1'b0, v} < ({1'b0, lo} + {1'b0, len}));
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Bus between the timing controller and the renderers: coordinates and strobes out,
// colour back in, plus the registered VGA pins.
interface vga_timing_ctrl_if;
  import vga_timing_ctrl_pkg::*;

  logic [8:0] row;
  coord_t     col;
  logic       pix_tick;
  logic       frame_start;
  color_t     d_in;
  logic       rdn;
  logic       hs;
  logic       vs;
  chan_t      r;
  chan_t      g;
  chan_t      b;

  modport master (
    output row, col, pix_tick, frame_start, rdn, hs, vs, r, g, b,
    input  d_in
  );

  modport slave (
    input  row, col, pix_tick, frame_start, rdn, hs, vs, r, g, b,
    output d_in
  );

endinterface

// File: rtl/vga_timing_ctrl_pixel_clk_en.sv
// Divides the system clock into a one-clk enable on the last clk of each pixel period.
module pixel_clk_en
  import vga_timing_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_tick
);

  localparam int unsigned   W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  DIV_LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg <= '0;
    end else if (pix_tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + W'(1);
    end
  end

  assign pix_tick = (div_cnt_reg == DIV_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel/line counters, coordinates for the renderers, and a
// one-pixel-late output stage keeping sync, blanking and colour aligned.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_640X480
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_ctrl_if.master bus
);

  localparam coord_t H_LAST   = TIMING.h_total - 10'd1;
  localparam coord_t V_LAST   = TIMING.v_total - 10'd1;
  localparam coord_t HS_START = TIMING.h_vis + TIMING.h_fp;
  localparam coord_t VS_START = TIMING.v_vis + TIMING.v_fp;

  logic               pix_tick;
  coord_t             h_cnt_reg, h_cnt_next;
  coord_t             v_cnt_reg, v_cnt_next;
  logic               h_last, v_last, active;
  logic               hs_reg, vs_reg, rdn_reg, frame_start_reg;
  logic [2:0][3:0]    chan_reg, chan_next;

  pixel_clk_en #(
    .CLK_DIV(int'(TIMING.clk_div))
  ) u_pixel_clk_en (
    .clk     (clk),
    .rst     (rst),
    .pix_tick(pix_tick)
  );

  always_comb begin
    h_last     = (h_cnt_reg == H_LAST);
    v_last     = (v_cnt_reg == V_LAST);
    active     = (h_cnt_reg < TIMING.h_vis) && (v_cnt_reg < TIMING.v_vis);
    h_cnt_next = h_last ? '0 : h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_last) begin
      v_cnt_next = v_last ? '0 : v_cnt_reg + 10'd1;
    end
  end

  // Channel 0 is R, 1 is G, 2 is B, matching the {B,G,R} packing of d_in.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan_next[gi] = active ? bus.d_in[gi*4 +: 4] : 4'h0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg       <= '0;
      v_cnt_reg       <= '0;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      rdn_reg         <= 1'b1;
      chan_reg        <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= pix_tick && h_last && v_last;
      if (pix_tick) begin
        h_cnt_reg <= h_cnt_next;
        v_cnt_reg <= v_cnt_next;
        hs_reg    <= ~in_window(h_cnt_reg, HS_START, TIMING.h_sync);
        vs_reg    <= ~in_window(v_cnt_reg, VS_START, TIMING.v_sync);
        rdn_reg   <= ~active;
        chan_reg  <= chan_next;
      end
    end
  end

  assign bus.row         = active ? v_cnt_reg[8:0] : 9'd0;
  assign bus.col         = active ? h_cnt_reg : 10'd0;
  assign bus.pix_tick    = pix_tick;
  assign bus.frame_start = frame_start_reg;
  assign bus.hs          = hs_reg;
  assign bus.vs          = vs_reg;
  assign bus.rdn         = rdn_reg;
  assign bus.r           = chan_reg[0];
  assign bus.g           = chan_reg[1];
  assign bus.b           = chan_reg[2];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size timing over two lines plus a shrunken timing
// instance that covers frame wrap, vertical sync and a mid-frame reset.
module tb_vga_timing_ctrl;
  import vga_timing_ctrl_pkg::*;

  localparam vga_timing_t T_SMALL = '{
    clk_div: 8'd2,  h_vis: 10'd16, h_fp: 10'd2, h_sync: 10'd4, h_total: 10'd26,
    v_vis:   10'd8, v_fp:  10'd2,  v_sync: 10'd2, v_total: 10'd14
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l = 1'b1;
  logic rst_s = 1'b1;

  vga_timing_ctrl_if bus_l ();
  vga_timing_ctrl_if bus_s ();

  vga_timing_ctrl #(.TIMING(VGA_640X480)) dut_l (.clk(clk), .rst(rst_l), .bus(bus_l.master));
  vga_timing_ctrl #(.TIMING(T_SMALL))     dut_s (.clk(clk), .rst(rst_s), .bus(bus_s.master));

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: everything is derived from n = clks since the last reset release.
  task automatic run_dut(input bit sel, input vga_timing_t t, input int cycles,
                         input bit hold_line, input int rst_frame);
    int n, c, ht, vt, frame_len, p, ph, h, v, q, hq, vq;
    int last_fs, hs_low;
    bit act, actq, did_rst, rst_now;
    logic rst_edge, hs_prev;
    logic [11:0] last_cap, din;
    logic e_tick, e_fs, e_hs, e_vs, e_rdn;
    logic [11:0] e_rgb;
    int e_row, e_col;
    logic o_tick, o_fs, o_hs, o_vs, o_rdn;
    logic [8:0] o_row;
    logic [9:0] o_col;
    logic [11:0] o_rgb;

    c = int'(t.clk_div); ht = int'(t.h_total); vt = int'(t.v_total);
    frame_len = c * ht * vt;
    n = 0; last_fs = -1; hs_low = 0; hs_prev = 1'b1; did_rst = 0; last_cap = '0;

    if (sel) rst_s = 1'b1; else rst_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < cycles; i++) begin
      rst_edge = sel ? rst_s : rst_l;
      @(posedge clk);
      #1;
      n = rst_edge ? 0 : n + 1;
      if (rst_edge) last_fs = -1;

      p = n / c; ph = n % c;
      h = p % ht; v = (p / ht) % vt;
      act    = (h < int'(t.h_vis)) && (v < int'(t.v_vis));
      e_tick = (ph == c - 1);
      e_row  = act ? v : 0;
      e_col  = act ? h : 0;
      e_fs   = (n > 0) && (n % frame_len == 0);
      if (p == 0) begin
        e_hs = 1'b1; e_vs = 1'b1; e_rdn = 1'b1; e_rgb = '0;
      end else begin
        q = p - 1; hq = q % ht; vq = (q / ht) % vt;
        actq  = (hq < int'(t.h_vis)) && (vq < int'(t.v_vis));
        e_hs  = !(hq >= int'(t.h_vis + t.h_fp) && hq < int'(t.h_vis + t.h_fp + t.h_sync));
        e_vs  = !(vq >= int'(t.v_vis + t.v_fp) && vq < int'(t.v_vis + t.v_fp + t.v_sync));
        e_rdn = !actq;
        e_rgb = actq ? last_cap : 12'h000;
      end

      if (sel) begin
        o_tick = bus_s.pix_tick; o_fs = bus_s.frame_start; o_hs = bus_s.hs; o_vs = bus_s.vs;
        o_rdn = bus_s.rdn; o_row = bus_s.row; o_col = bus_s.col;
        o_rgb = {bus_s.b, bus_s.g, bus_s.r};
      end else begin
        o_tick = bus_l.pix_tick; o_fs = bus_l.frame_start; o_hs = bus_l.hs; o_vs = bus_l.vs;
        o_rdn = bus_l.rdn; o_row = bus_l.row; o_col = bus_l.col;
        o_rgb = {bus_l.b, bus_l.g, bus_l.r};
      end

      check_eq("pix_tick", 32'(o_tick), 32'(e_tick));
      check_eq("frame_start", 32'(o_fs), 32'(e_fs));
      check_eq("hs", 32'(o_hs), 32'(e_hs));
      check_eq("vs", 32'(o_vs), 32'(e_vs));
      check_eq("rdn", 32'(o_rdn), 32'(e_rdn));
      check_eq("row", 32'(o_row), 32'(e_row));
      check_eq("col", 32'(o_col), 32'(e_col));
      check_eq("rgb", 32'(o_rgb), 32'(e_rgb));

      if (o_fs === 1'b1) begin
        if (last_fs >= 0) check_eq("fs_period", 32'(i - last_fs), 32'(frame_len));
        last_fs = i;
      end
      if (o_hs === 1'b0) begin
        hs_low++;
      end else begin
        if (hs_prev === 1'b0 && !rst_edge) check_eq("hs_width", 32'(hs_low), 32'(int'(t.h_sync) * c));
        hs_low = 0;
      end
      hs_prev = o_hs;

      // Pulse reset once in the middle of the last vertical-sync line of the chosen frame.
      rst_now = sel && !did_rst && (n / frame_len == rst_frame) && (h == ht / 2) && (ph == 0) &&
                (v == int'(t.v_vis + t.v_fp + t.v_sync) - 1);
      if (rst_now) begin
        check_eq("vs_before_rst", 32'(o_vs), 32'd0);
        did_rst = 1;
      end

      din = (hold_line && n < c * ht) ? 12'h12c : 12'($urandom);
      if (e_tick) last_cap = din;
      if (sel) begin
        rst_s = rst_now; bus_s.d_in = din;
      end else begin
        rst_l = rst_now; bus_l.d_in = din;
      end
    end
    if (sel && rst_frame >= 0) check_eq("rst_seen", 32'(did_rst), 32'd1);
  endtask

  initial begin
    bus_l.d_in = '0;
    bus_s.d_in = '0;
    run_dut(1'b0, VGA_640X480, 2 * 3200 + 400, 1'b1, -1);
    rst_l = 1'b1;
    run_dut(1'b1, T_SMALL, 4 * 728, 1'b0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
